// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - per-stage clock-enable generator with stall merge and interrupt drain FSM
// Optional statistics counters are built when PIPE_HOLD_STATS_EN is defined.
module pipe_hold_ctrl #(
    parameter int STAGES  = 4,
    parameter int NSRC    = 2,
    parameter int IRQ_NUM = 4,
    localparam int SW     = $clog2(STAGES),
    localparam int IW     = $clog2(IRQ_NUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stallb,
    input  logic [NSRC-1:0]      stall_req,
    input  logic [NSRC*SW-1:0]   stall_lvl,
    input  logic [IRQ_NUM-1:0]   irq,
    input  logic [IRQ_NUM-1:0]   irq_mask,
    input  logic                 irq_ack,
`ifdef PIPE_HOLD_STATS_EN
    input  logic                 stat_clr,
    output logic [15:0]          stat_stall_cnt,
    output logic [15:0]          stat_irq_cnt,
`endif
    output logic [STAGES-1:0]    stg_en,
    output logic [STAGES-1:0]    stg_bubble,
    output logic                 irq_take,
    output logic [IW-1:0]        irq_id,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_TAKE  = 2'd2;

    logic [1:0]         state;
    logic [SW-1:0]      cnt;
    logic [IW-1:0]      id_q;
    logic [IRQ_NUM-1:0] pend;
    logic [IRQ_NUM-1:0] irq_q;

    logic               req_any;
    logic               hold;
    logic [SW-1:0]      depth;
    logic [SW-1:0]      lvl;
    logic [IRQ_NUM-1:0] cand;
    logic               win_vld;
    logic [IW-1:0]      win_id;
    logic [IRQ_NUM-1:0] ack_clr;
    logic               ack_ok;

    // Deepest frozen stage over all asserted requesters, clamped to the last stage
    always_comb begin
        req_any = 1'b0;
        depth   = '0;
        lvl     = '0;
        for (int i = 0; i < NSRC; i++) begin
            lvl = stall_lvl[i*SW +: SW];
            if (int'(lvl) > STAGES - 1) lvl = SW'(STAGES - 1);
            if (stall_req[i]) begin
                req_any = 1'b1;
                if (lvl > depth) depth = lvl;
            end
        end
    end

    // While draining or taking, fetch is always frozen; with no request depth is already 0
    assign hold = req_any || (state != S_IDLE);

    always_comb begin
        stg_en     = '0;
        stg_bubble = '0;
        if (reset && stallb) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_en[k]     = !hold || (k > int'(depth));
                stg_bubble[k] = hold && (k == int'(depth) + 1);
            end
        end
    end

    assign cand = pend & ~irq_mask;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int j = IRQ_NUM - 1; j >= 0; j--) begin
            if (cand[j]) begin
                win_vld = 1'b1;
                win_id  = IW'(j);
            end
        end
    end

    assign ack_ok  = (state == S_TAKE) && irq_ack;
    assign ack_clr = ack_ok ? (IRQ_NUM'(1) << id_q) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            id_q  <= '0;
            pend  <= '0;
            irq_q <= '0;
        end else begin
            irq_q <= irq;
            // A fresh edge in the ack cycle re-arms the line being cleared
            pend  <= (pend & ~ack_clr) | (irq & ~irq_q);
            case (state)
                S_IDLE: begin
                    if (win_vld && stallb) begin
                        id_q  <= win_id;
                        cnt   <= SW'(STAGES - 1);
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (stg_en[STAGES-1]) begin
                        cnt <= cnt - SW'(1);
                        if (cnt == SW'(1)) state <= S_TAKE;
                    end
                end
                S_TAKE: begin
                    if (irq_ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign irq_take = (state == S_TAKE);
    assign irq_id   = id_q;
    assign busy     = (state != S_IDLE);

`ifdef PIPE_HOLD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_stall_cnt <= '0;
            stat_irq_cnt   <= '0;
        end else if (stat_clr) begin
            stat_stall_cnt <= '0;
            stat_irq_cnt   <= '0;
        end else begin
            if (!stg_en[0] && stat_stall_cnt != 16'hFFFF) stat_stall_cnt <= stat_stall_cnt + 16'd1;
            if (ack_ok && stat_irq_cnt != 16'hFFFF) stat_irq_cnt <= stat_irq_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb/tb_pipe_hold_ctrl.sv - directed and randomized bench for pipe_hold_ctrl against a cycle model
module tb_pipe_hold_ctrl;

    localparam int STAGES  = 4;
    localparam int NSRC    = 2;
    localparam int IRQ_NUM = 4;
    localparam int SW      = 2;
    localparam int IW      = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 stallb = 1'b1;
    logic [NSRC-1:0]      stall_req = '0;
    logic [NSRC*SW-1:0]   stall_lvl = '0;
    logic [IRQ_NUM-1:0]   irq = '0;
    logic [IRQ_NUM-1:0]   irq_mask = '0;
    logic                 irq_ack = 1'b0;
    logic                 stat_clr = 1'b0;
    logic [STAGES-1:0]    stg_en;
    logic [STAGES-1:0]    stg_bubble;
    logic                 irq_take;
    logic [IW-1:0]        irq_id;
    logic                 busy;
`ifdef PIPE_HOLD_STATS_EN
    logic [15:0]          stat_stall_cnt;
    logic [15:0]          stat_irq_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: phase 0 idle, 1 draining, 2 taking
    int                 m_phase;
    int                 m_left;
    int                 m_id;
    logic [IRQ_NUM-1:0] m_pend;
    logic [IRQ_NUM-1:0] m_prev;
    int                 m_stall_cnt;
    int                 m_irq_cnt;
    logic [STAGES-1:0]  e_en;
    logic [STAGES-1:0]  e_bub;
    int                 drain_cnt;
    bit                 seen_take;

    pipe_hold_ctrl #(.STAGES(STAGES), .NSRC(NSRC), .IRQ_NUM(IRQ_NUM)) dut (
        .clk(clk),
        .reset(reset),
        .stallb(stallb),
        .stall_req(stall_req),
        .stall_lvl(stall_lvl),
        .irq(irq),
        .irq_mask(irq_mask),
        .irq_ack(irq_ack),
`ifdef PIPE_HOLD_STATS_EN
        .stat_clr(stat_clr),
        .stat_stall_cnt(stat_stall_cnt),
        .stat_irq_cnt(stat_irq_cnt),
`endif
        .stg_en(stg_en),
        .stg_bubble(stg_bubble),
        .irq_take(irq_take),
        .irq_id(irq_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_id = 0;
        m_pend = '0; m_prev = '0;
        m_stall_cnt = 0; m_irq_cnt = 0;
    endtask

    task automatic model_comb();
        int d;
        d = -1;
        for (int i = 0; i < NSRC; i++) begin
            if (stall_req[i]) begin
                int l;
                l = int'(stall_lvl[i*SW +: SW]);
                if (l > STAGES - 1) l = STAGES - 1;
                if (l > d) d = l;
            end
        end
        if (m_phase != 0 && d < 0) d = 0;
        if (!reset || !stallb) begin
            e_en = '0; e_bub = '0;
        end else if (d < 0) begin
            e_en = '1; e_bub = '0;
        end else begin
            e_en  = STAGES'(((1 << STAGES) - 1) & ~((1 << (d + 1)) - 1));
            e_bub = (d + 1 < STAGES) ? STAGES'(1 << (d + 1)) : '0;
        end
    endtask

    task automatic model_update();
        logic [IRQ_NUM-1:0] clr;
        logic [IRQ_NUM-1:0] cand;
        bit acc;
        acc  = (m_phase == 2) && irq_ack;
        clr  = acc ? (IRQ_NUM'(1) << m_id) : '0;
        cand = m_pend & ~irq_mask;
        if (stat_clr) begin
            m_stall_cnt = 0; m_irq_cnt = 0;
        end else begin
            if (!e_en[0] && m_stall_cnt < 65535) m_stall_cnt++;
            if (acc && m_irq_cnt < 65535) m_irq_cnt++;
        end
        case (m_phase)
            0: if (stallb && cand != 0) begin
                for (int j = IRQ_NUM - 1; j >= 0; j--) if (cand[j]) m_id = j;
                m_left = STAGES - 1;
                m_phase = 1;
            end
            1: if (e_en[STAGES-1]) begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
            default: if (irq_ack) m_phase = 0;
        endcase
        m_pend = (m_pend & ~clr) | (irq & ~m_prev);
        m_prev = irq;
    endtask

    task automatic cycle();
        #1;
        if (!reset) model_reset();
        model_comb();
        chk("stg_en", 32'(stg_en), 32'(e_en));
        chk("stg_bubble", 32'(stg_bubble), 32'(e_bub));
        chk("irq_take", 32'(irq_take), (m_phase == 2) ? 32'd1 : 32'd0);
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
`ifdef PIPE_HOLD_STATS_EN
        chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'(m_stall_cnt));
        chk("stat_irq_cnt", 32'(stat_irq_cnt), 32'(m_irq_cnt));
`endif
        if (busy && !irq_take) drain_cnt++;
        if (irq_take) seen_take = 1'b1;
        @(posedge clk);
        if (reset) model_update();
        @(negedge clk);
    endtask

    task automatic run_until_take();
        seen_take = 1'b0;
        for (int n = 0; n < 30 && !seen_take; n++) cycle();
        chk("take_reached", 32'(seen_take), 32'd1);
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cycle();

        // Idle after reset release
        reset = 1'b1;
        #1;
        chk("idle_en", 32'(stg_en), 32'hF);
        chk("idle_bub", 32'(stg_bubble), 32'h0);
        chk("idle_take", 32'(irq_take), 32'd0);
        cycle();

        // Multi-source freeze
        stall_req = 2'b11; stall_lvl = {2'd0, 2'd1};
        #1;
        chk("multi_en", 32'(stg_en), 32'hC);
        chk("multi_bub", 32'(stg_bubble), 32'h4);
        cycle();
        stall_req = 2'b10;
        #1;
        chk("single_en", 32'(stg_en), 32'hE);
        chk("single_bub", 32'(stg_bubble), 32'h2);
        cycle();

        // Global hold
        stall_req = '0; stallb = 1'b0;
        #1;
        chk("hold_en", 32'(stg_en), 32'h0);
        chk("hold_bub", 32'(stg_bubble), 32'h0);
        repeat (3) cycle();
        stallb = 1'b1;

        // Two lines rise together: lowest wins, the other stays pending
        irq = 4'b0110;
        cycle();
        drain_cnt = 0;
        run_until_take();
        chk("drain_len", 32'(drain_cnt), 32'd3);
        chk("first_id", 32'(irq_id), 32'd1);
        do_ack();
        irq = '0;
        cycle();
        #1;
        chk("second_busy", 32'(busy), 32'd1);
        chk("second_id", 32'(irq_id), 32'd2);
        run_until_take();
        do_ack();

        // Drain extended by a full-depth stall
        irq = 4'b0001;
        cycle();
        cycle();
        stall_req = 2'b01; stall_lvl = {2'd0, 2'd3};
        drain_cnt = 0;
        cycle();
        cycle();
        stall_req = '0;
        run_until_take();
        chk("stall_drain_len", 32'(drain_cnt), 32'd5);
        do_ack();

        // Reset in the middle of a drain
        irq = '0;
        cycle();
        irq = 4'b1000;
        cycle();
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(stg_en), 32'h0);
        irq = '0;
        cycle();
        reset = 1'b1;
        cycle();
        cycle();
        #1;
        chk("post_rst_idle", 32'(busy), 32'd0);

        // New edge on the acknowledged line in the ack cycle
        irq = 4'b0001;
        cycle();
        irq = '0;
        cycle();
        run_until_take();
        irq = 4'b0001;
        do_ack();
        irq = '0;
        cycle();
        #1;
        chk("race_busy", 32'(busy), 32'd1);
        chk("race_id", 32'(irq_id), 32'd0);
        run_until_take();
        do_ack();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) != 0);
            stallb    = ($urandom_range(0, 7) != 0);
            stall_req = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
            stall_lvl = (NSRC*SW)'($urandom);
            if ($urandom_range(0, 3) == 0) irq = IRQ_NUM'($urandom);
            if ($urandom_range(0, 7) == 0) irq_mask = IRQ_NUM'($urandom);
            irq_ack   = ($urandom_range(0, 3) == 0);
            stat_clr  = ($urandom_range(0, 31) == 0);
            cycle();
        end
        reset = 1'b1; irq_ack = 1'b0; stat_clr = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
